// File: rtl/pipe_stage_hs.sv
// pipe_stage_hs: inter-stage register with valid/ready handshake,
// flush, bubble-masked control and an optional two-entry skid buffer.
module pipe_stage_hs #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 4,
  parameter int SKID   = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        occupancy
);

  localparam bit HAS_SKID = (SKID != 0);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [DATA_W-1:0] main_data;
  logic [CTRL_W-1:0] main_ctrl;
  logic [DATA_W-1:0] skid_data;
  logic [CTRL_W-1:0] skid_ctrl;

  logic main_valid;
  logic skid_valid;
  logic in_fire;
  logic out_fire;
  logic load_main;
  logic load_skid;
  logic skid_to_main;

  assign main_valid = (state_q != EMPTY);
  assign skid_valid = (state_q == TWO);

  // skid variant decodes ready from state only; bypass variant
  // lets a consuming downstream make room in the same cycle
  always_comb begin
    if (HAS_SKID) begin
      in_ready = (state_q != TWO);
    end else begin
      in_ready = ~main_valid | out_ready;
    end
  end

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;

  assign out_valid = main_valid;
  assign out_data  = main_data;
  assign out_ctrl  = main_valid ? main_ctrl : '0;
  assign occupancy = {1'b0, main_valid} + {1'b0, skid_valid};

  // occupancy state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // next state and register load strobes; flush wins over all
  always_comb begin
    state_d      = state_q;
    load_main    = 1'b0;
    load_skid    = 1'b0;
    skid_to_main = 1'b0;
    unique case (state_q)
      EMPTY: begin
        if (in_fire) begin
          state_d   = ONE;
          load_main = 1'b1;
        end
      end
      ONE: begin
        if (in_fire && out_fire) begin
          load_main = 1'b1;
        end else if (in_fire && HAS_SKID) begin
          state_d   = TWO;
          load_skid = 1'b1;
        end else if (out_fire) begin
          state_d = EMPTY;
        end
      end
      TWO: begin
        if (out_fire) begin
          state_d      = ONE;
          skid_to_main = 1'b1;
        end
      end
      default: begin
        state_d = EMPTY;
      end
    endcase
    if (flush) begin
      state_d      = EMPTY;
      load_main    = 1'b0;
      load_skid    = 1'b0;
      skid_to_main = 1'b0;
    end
  end

  // main register: fresh input or the entry parked in skid
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_data <= '0;
      main_ctrl <= '0;
    end else if (load_main) begin
      main_data <= in_data;
      main_ctrl <= in_ctrl;
    end else if (skid_to_main) begin
      main_data <= skid_data;
      main_ctrl <= skid_ctrl;
    end
  end

  // skid register: absorbs the one entry accepted during a stall
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      skid_data <= '0;
      skid_ctrl <= '0;
    end else if (load_skid) begin
      skid_data <= in_data;
      skid_ctrl <= in_ctrl;
    end
  end

endmodule

// File: tb/tb_pipe_stage_hs.sv
// tb_pipe_stage_hs: directed bench for both skid variants
// of pipe_stage_hs with hand-computed expectations.
module tb_pipe_stage_hs;

  logic        clk = 1'b0;
  logic        rst_n;

  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [3:0]  in_ctrl;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [3:0]  out_ctrl;
  logic [1:0]  occupancy;

  logic        z_flush;
  logic        z_in_valid;
  logic        z_in_ready;
  logic [31:0] z_in_data;
  logic [3:0]  z_in_ctrl;
  logic        z_out_valid;
  logic        z_out_ready;
  logic [31:0] z_out_data;
  logic [3:0]  z_out_ctrl;
  logic [1:0]  z_occupancy;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pipe_stage_hs #(.DATA_W(32), .CTRL_W(4), .SKID(1)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_ctrl   (in_ctrl),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ctrl  (out_ctrl),
    .occupancy (occupancy)
  );

  pipe_stage_hs #(.DATA_W(32), .CTRL_W(4), .SKID(0)) u_dut0 (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (z_flush),
    .in_valid  (z_in_valid),
    .in_ready  (z_in_ready),
    .in_data   (z_in_data),
    .in_ctrl   (z_in_ctrl),
    .out_valid (z_out_valid),
    .out_ready (z_out_ready),
    .out_data  (z_out_data),
    .out_ctrl  (z_out_ctrl),
    .occupancy (z_occupancy)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n       = 1'b0;
    flush       = 1'b0;
    in_valid    = 1'b0;
    in_data     = '0;
    in_ctrl     = '0;
    out_ready   = 1'b0;
    z_flush     = 1'b0;
    z_in_valid  = 1'b0;
    z_in_data   = '0;
    z_in_ctrl   = '0;
    z_out_ready = 1'b0;

    #12;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_ctrl", {28'd0, out_ctrl}, 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_occ", {30'd0, occupancy}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_z_in_ready", {31'd0, z_in_ready}, 32'd1);
    rst_n = 1'b1;
    tick();

    // streaming 0..9
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_ctrl   = 4'hF;
    for (int i = 0; i < 10; i++) begin
      in_data = i;
      #1;
      chk("stream_in_ready", {31'd0, in_ready}, 32'd1);
      tick();
      chk("stream_valid", {31'd0, out_valid}, 32'd1);
      chk("stream_data", out_data, i);
      chk("stream_ctrl", {28'd0, out_ctrl}, 32'hF);
      chk("stream_occ", {30'd0, occupancy}, 32'd1);
    end
    in_valid = 1'b0;
    tick();
    chk("drain_valid", {31'd0, out_valid}, 32'd0);

    // bubble masking
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bubble_valid", {31'd0, out_valid}, 32'd0);
      chk("bubble_ctrl", {28'd0, out_ctrl}, 32'd0);
    end

    // stall / skid
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_ctrl   = 4'h3;
    in_data   = 32'hA;
    tick();
    chk("stall1_data", out_data, 32'hA);
    chk("stall1_in_ready", {31'd0, in_ready}, 32'd1);
    in_data = 32'hB;
    tick();
    chk("stall2_data", out_data, 32'hA);
    chk("stall2_occ", {30'd0, occupancy}, 32'd2);
    chk("stall2_in_ready", {31'd0, in_ready}, 32'd0);
    in_data = 32'hC;
    tick();
    chk("stall3_data", out_data, 32'hA);
    chk("stall3_occ", {30'd0, occupancy}, 32'd2);
    chk("stall3_in_ready", {31'd0, in_ready}, 32'd0);
    chk("stall3_ctrl", {28'd0, out_ctrl}, 32'h3);
    out_ready = 1'b1;
    tick();
    chk("release_b", out_data, 32'hB);
    chk("release_b_occ", {30'd0, occupancy}, 32'd1);
    chk("release_in_ready", {31'd0, in_ready}, 32'd1);
    tick();
    chk("release_c", out_data, 32'hC);
    chk("release_c_valid", {31'd0, out_valid}, 32'd1);
    in_valid = 1'b0;
    tick();
    chk("release_empty", {31'd0, out_valid}, 32'd0);

    // flush while TWO with an incoming entry
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_ctrl   = 4'h5;
    in_data   = 32'h1;
    tick();
    in_data = 32'h2;
    tick();
    chk("pre_flush_occ", {30'd0, occupancy}, 32'd2);
    in_data = 32'h55;
    flush   = 1'b1;
    tick();
    chk("flush_valid", {31'd0, out_valid}, 32'd0);
    chk("flush_occ", {30'd0, occupancy}, 32'd0);
    chk("flush_in_ready", {31'd0, in_ready}, 32'd1);
    chk("flush_ctrl", {28'd0, out_ctrl}, 32'd0);
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("post_flush_valid", {31'd0, out_valid}, 32'd0);
    in_valid = 1'b1;
    in_data  = 32'h66;
    tick();
    chk("post_flush_data", out_data, 32'h66);
    chk("post_flush_v", {31'd0, out_valid}, 32'd1);
    in_valid = 1'b0;
    tick();

    // SKID=0 variant
    z_out_ready = 1'b0;
    z_in_valid  = 1'b1;
    z_in_ctrl   = 4'h9;
    z_in_data   = 32'h7;
    tick();
    chk("z_load_data", z_out_data, 32'h7);
    chk("z_full_ready", {31'd0, z_in_ready}, 32'd0);
    chk("z_occ", {30'd0, z_occupancy}, 32'd1);
    z_out_ready = 1'b1;
    z_in_data   = 32'h8;
    #1;
    chk("z_comb_ready", {31'd0, z_in_ready}, 32'd1);
    tick();
    chk("z_reload_data", z_out_data, 32'h8);
    chk("z_reload_valid", {31'd0, z_out_valid}, 32'd1);
    chk("z_reload_occ", {30'd0, z_occupancy}, 32'd1);
    z_out_ready = 1'b0;
    z_in_data   = 32'h9;
    tick();
    chk("z_hold_data", z_out_data, 32'h8);
    z_in_valid  = 1'b0;
    z_out_ready = 1'b1;
    tick();
    chk("z_empty_valid", {31'd0, z_out_valid}, 32'd0);
    chk("z_empty_ctrl", {28'd0, z_out_ctrl}, 32'd0);

    // async reset with two entries held
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_ctrl   = 4'hF;
    in_data   = 32'h11;
    tick();
    in_data = 32'h22;
    tick();
    chk("ar_pre_occ", {30'd0, occupancy}, 32'd2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_valid", {31'd0, out_valid}, 32'd0);
    chk("ar_ctrl", {28'd0, out_ctrl}, 32'd0);
    chk("ar_data", out_data, 32'd0);
    chk("ar_occ", {30'd0, occupancy}, 32'd0);
    chk("ar_in_ready", {31'd0, in_ready}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
